uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Serial program loader that sits upstream of the CPU's RAM: receives a 16-byte program over a UART line, writes it byte-by-byte into RAM starting at address 0, and holds the CPU while loading. On completion it issues a one-cycle CPU reset pulse so execution restarts from address 0. It runs on the onboard system clock, not the CPU clock, so loading works with the CPU clock halted or in manual mode.

## Interface
Parameters:
- CLK_FREQ, 27_000_000 — system clock frequency in Hz.
- BAUD, 115200 — UART bit rate.
- MEM_DEPTH, 16 — bytes per program; power of two.
- ADDR_WIDTH, 4 — log2(MEM_DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  serial input, idle high, 8N1, LSB first; asynchronous.
- load_en  input  1  load-mode switch, level; asynchronous.
- ram_we  output  1  one-cycle RAM write strobe.
- ram_addr  output  ADDR_WIDTH  write address.
- ram_data  output  8  write data.
- cpu_hold  output  1  high while loading; CPU must not advance.
- cpu_rst_pulse  output  1  one-cycle pulse on successful completion.
- done  output  1  high after a successful load until load_en drops.
- byte_count  output  ADDR_WIDTH+1  bytes accepted in the current load.
- frame_err  output  1  sticky; a byte had a low stop bit.
- chk_err  output  1  sticky checksum mismatch; constant 0 without LOADER_CHECKSUM_EN.

## Operation
- uart_rx and load_en each pass through a 2-FF synchronizer; uart_rx synchronizer resets to 1.
- CLKS_PER_BIT = CLK_FREQ / BAUD (integer division); HALF = CLKS_PER_BIT / 2.
- RX FSM: RX_IDLE -> RX_START on a synchronized falling edge. RX_START: at HALF cycles re-sample; a low sample goes to RX_DATA, a high sample returns to RX_IDLE (glitch, nothing reported). RX_DATA: 8 samples, one every CLKS_PER_BIT cycles, shifted LSB first. RX_STOP: one sample after CLKS_PER_BIT cycles. A high stop bit raises an internal byte_valid for one cycle. A low stop bit sets frame_err and discards the byte. Either outcome returns to RX_IDLE.
- Loader FSM states:
  - L_IDLE: cpu_hold=0. load_en_sync=1 -> L_LOAD; on entry clear addr, byte_count, frame_err, chk_err.
  - L_LOAD: cpu_hold=1. Each byte_valid writes the byte to ram_addr, then increments addr (wraps to 0 after MEM_DEPTH-1) and byte_count. After the MEM_DEPTH-th byte, go to L_CHECK if the macro is defined, else go to L_DONE.
  - L_CHECK: cpu_hold=1. The next byte_valid is compared with the 8-bit modulo-256 sum of all program bytes. Match -> L_DONE. Mismatch -> set chk_err and stay in L_CHECK. No RAM write occurs in this state.
  - L_DONE: done=1, cpu_hold=0. Entering L_DONE asserts cpu_rst_pulse for exactly one cycle.
- Leaving load mode:
  - load_en_sync=0 in L_LOAD or L_CHECK aborts to L_IDLE: no cpu_rst_pulse, done stays 0, RAM contents already written remain.
  - load_en_sync=0 in L_DONE -> L_IDLE with done=0.
- Bytes arriving in L_IDLE or L_DONE are received and ignored, except that a low stop bit still sets frame_err.
- A frame error does not abort the load; addr is not advanced.

## Timing
- Reset values: ram_we=0, ram_addr=0, ram_data=0, cpu_hold=0, cpu_rst_pulse=0, done=0, byte_count=0, frame_err=0, chk_err=0; both FSMs in their idle state.
- Stop-bit sample occurs HALF + 9·CLKS_PER_BIT cycles after the RX_START entry cycle.
- byte_valid is asserted in the cycle after the stop-bit sample.
- ram_we, ram_addr and ram_data are registered and valid in the cycle after byte_valid. addr and byte_count update in that same cycle.
- load_en edge to state change takes 3 cycles: 2 synchronizer cycles plus 1 register.
- cpu_hold deasserts and cpu_rst_pulse asserts in the same cycle, one cycle after the final write strobe or checksum match.
- Asynchronous rst mid-byte or mid-load forces all reset values immediately. No partial write is issued.

## Configuration
- LOADER_CHECKSUM_EN defined: a trailing checksum byte is required (L_CHECK present, chk_err live).
- Not defined: L_CHECK is absent, completion occurs after MEM_DEPTH bytes, and chk_err is tied 0.

## Test plan
Bench uses CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16).
- Full load: load_en=1, send bytes 0x1E,0x2F,0xE0,0xF0,0x00×12 -> 16 ram_we strobes at addr 0..15 with matching data. Then cpu_hold=0, one cpu_rst_pulse, done=1, byte_count=16.
- Framing error: send 0x55 with stop bit low during L_LOAD -> no ram_we, frame_err=1, byte_count unchanged. Next good byte 0xAA is written at the same addr.
- Glitch: uart_rx low for 6 cycles in L_LOAD -> no write, no frame_err, RX returns to idle.
- Abort: load_en=0 after 5 bytes -> L_IDLE, cpu_hold=0, no cpu_rst_pulse, done=0, byte_count=5. A new load_en=1 restarts at addr 0 with byte_count=0.
- Reset mid-byte: assert rst during data bit 4 -> all outputs at reset values at once. A following full load succeeds.
- Checksum (LOADER_CHECKSUM_EN): 16 bytes of 0x11 then 0x10 -> done=1. Resend with trailer 0x11 -> chk_err=1, cpu_hold stays 1.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// RAM write port driven by the program loader: one-cycle strobe with address and byte.
interface uart_program_loader_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_data;

  modport master (output ram_we, ram_addr, ram_data);
  modport slave  (input  ram_we, ram_addr, ram_data);
endinterface

// File: rtl/uart_program_loader.sv
// UART 8N1 program loader: streams MEM_DEPTH bytes into RAM from address 0, holds the CPU
// meanwhile and pulses its reset on completion. Define LOADER_CHECKSUM_EN for a trailer checksum.
module uart_program_loader #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_uart_rx,
  input  logic                  i_load_en,
  uart_program_loader_if.master ram,
  output logic                  o_cpu_hold,
  output logic                  o_cpu_rst_pulse,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_byte_count,
  output logic                  o_frame_err,
  output logic                  o_chk_err
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]    CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH:0] FULL     = (ADDR_WIDTH+1)'(MEM_DEPTH);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] L_IDLE  = 2'd0;
  localparam logic [1:0] L_LOAD  = 2'd1;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [1:0] L_CHECK = 2'd2;
`endif
  localparam logic [1:0] L_DONE  = 2'd3;

  logic r_rx_s1, r_rx_s2, r_rx_s3;
  logic r_le_s1, r_le_s2;
  logic w_rx, w_rx_fall, w_le;

  // Third rx stage exists only to detect the falling edge of the synchronized line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
      r_le_s1 <= 1'b0;
      r_le_s2 <= 1'b0;
    end else begin
      r_rx_s1 <= i_uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      r_le_s1 <= i_load_en;
      r_le_s2 <= r_le_s1;
    end
  end

  assign w_rx      = r_rx_s2;
  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
  assign w_le      = r_le_s2;

  logic [1:0]       r_rx_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_byte_vld;
  logic             r_frame_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state  <= RX_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_bad <= 1'b0;
    end else begin
      r_byte_vld  <= 1'b0;
      r_frame_bad <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= RX_START;
            r_cnt      <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == CNT_BIT) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == CNT_BIT) begin
            r_cnt       <= '0;
            r_rx_state  <= RX_IDLE;
            r_byte_vld  <= w_rx;
            r_frame_bad <= ~w_rx;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  logic [1:0]            r_l_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [7:0]            r_ram_data;
  logic                  r_pulse;
  logic                  r_frame_err;
`ifdef LOADER_CHECKSUM_EN
  logic                  r_chk_err;
  logic [7:0]            r_sum;
`endif

  // Completion is taken one cycle after the last write, so the hold drops with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_l_state   <= L_IDLE;
      r_addr      <= '0;
      r_count     <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_pulse     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_chk_err   <= 1'b0;
      r_sum       <= '0;
`endif
    end else begin
      r_ram_we <= 1'b0;
      r_pulse  <= 1'b0;
      if (r_frame_bad) r_frame_err <= 1'b1;
      case (r_l_state)
        L_IDLE: begin
          if (w_le) begin
            r_l_state   <= L_LOAD;
            r_addr      <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_chk_err   <= 1'b0;
            r_sum       <= '0;
`endif
          end
        end
        L_LOAD: begin
          if (!w_le) begin
            r_l_state <= L_IDLE;
          end else if (r_count == FULL) begin
`ifdef LOADER_CHECKSUM_EN
            r_l_state <= L_CHECK;
`else
            r_l_state <= L_DONE;
            r_pulse   <= 1'b1;
`endif
          end else if (r_byte_vld) begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_addr;
            r_ram_data <= r_shift;
            r_addr     <= r_addr + 1'b1;
            r_count    <= r_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= r_sum + r_shift;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        L_CHECK: begin
          if (!w_le) begin
            r_l_state <= L_IDLE;
          end else if (r_byte_vld) begin
            if (r_shift == r_sum) begin
              r_l_state <= L_DONE;
              r_pulse   <= 1'b1;
            end else begin
              r_chk_err <= 1'b1;
            end
          end
        end
`endif
        L_DONE: begin
          if (!w_le) r_l_state <= L_IDLE;
        end
        default: r_l_state <= L_IDLE;
      endcase
    end
  end

  assign ram.ram_we       = r_ram_we;
  assign ram.ram_addr     = r_ram_addr;
  assign ram.ram_data     = r_ram_data;
  assign o_done           = (r_l_state == L_DONE);
  assign o_cpu_hold       = (r_l_state != L_IDLE) && (r_l_state != L_DONE);
  assign o_cpu_rst_pulse  = r_pulse;
  assign o_byte_count     = r_count;
  assign o_frame_err      = r_frame_err;
`ifdef LOADER_CHECKSUM_EN
  assign o_chk_err        = r_chk_err;
`else
  assign o_chk_err        = 1'b0;
`endif
endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader against a byte-level load model.
module tb_uart_program_loader;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int CPB   = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHECKSUM = 1'b1;
`else
  localparam bit CHECKSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic load_en = 1'b0;
  logic cpu_hold, cpu_rst_pulse, done, frame_err, chk_err;
  logic [AW:0] byte_count;

  uart_program_loader_if #(.ADDR_WIDTH(AW)) ram_if ();

  uart_program_loader #(
    .CLK_FREQ(16), .BAUD(1), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .i_uart_rx(uart_rx), .i_load_en(load_en), .ram(ram_if),
    .o_cpu_hold(cpu_hold), .o_cpu_rst_pulse(cpu_rst_pulse), .o_done(done),
    .o_byte_count(byte_count), .o_frame_err(frame_err), .o_chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed write strobes and CPU reset pulses
  logic [11:0] obs_q[$];
  int pulse_cnt = 0;
  int pulse_bad = 0;
  logic prev_we = 1'b0;

  always @(posedge clk) begin
    #1;
    if (ram_if.ram_we) obs_q.push_back({ram_if.ram_addr, ram_if.ram_data});
    if (cpu_rst_pulse) begin
      pulse_cnt++;
      if (cpu_hold || !done) pulse_bad++;
      if (!CHECKSUM && !prev_we) pulse_bad++;
    end
    prev_we = ram_if.ram_we;
  end

  // Byte-level model of a load session
  logic [11:0] exp_q[$];
  int m_on = 0, m_count = 0, m_frame = 0, m_chk = 0, m_done = 0, m_pulses = 0;
  logic [7:0] m_sum = 8'h00;

  task automatic model_reset();
    m_on = 0; m_count = 0; m_frame = 0; m_chk = 0; m_done = 0; m_sum = 8'h00;
  endtask

  task automatic model_start();
    m_on = 1; m_count = 0; m_frame = 0; m_chk = 0; m_done = 0; m_sum = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] d, input bit ok);
    if (!ok) begin
      m_frame = 1;
    end else if (m_on != 0 && m_done == 0) begin
      if (m_count < DEPTH) begin
        exp_q.push_back({4'(m_count % DEPTH), d});
        m_count++;
        m_sum = 8'(m_sum + d);
        if (m_count == DEPTH && !CHECKSUM) begin m_done = 1; m_pulses++; end
      end else if (d == m_sum) begin
        m_done = 1; m_pulses++;
      end else begin
        m_chk = 1;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit ok);
    uart_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin uart_rx = d[i]; tick(CPB); end
    uart_rx = ok; tick(CPB);
    uart_rx = 1'b1; tick(8);
    model_byte(d, ok);
  endtask

  task automatic start_load();
    load_en = 1'b1; tick(6);
    model_start();
  endtask

  task automatic stop_load();
    load_en = 1'b0; tick(6);
    m_on = 0; m_done = 0;
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic compare_state(input string tag);
    check({tag, "/byte_count"}, 32'(byte_count), m_count);
    check({tag, "/frame_err"}, 32'(frame_err), m_frame);
    check({tag, "/chk_err"}, 32'(chk_err), m_chk);
    check({tag, "/done"}, 32'(done), m_done);
    check({tag, "/cpu_hold"}, 32'(cpu_hold), (m_on != 0 && m_done == 0) ? 1 : 0);
    check({tag, "/pulses"}, pulse_cnt, m_pulses);
    check({tag, "/pulse_timing"}, pulse_bad, 0);
    check({tag, "/nwrites"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "/write"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/ram_we"}, 32'(ram_if.ram_we), 0);
    check({tag, "/ram_addr"}, 32'(ram_if.ram_addr), 0);
    check({tag, "/ram_data"}, 32'(ram_if.ram_data), 0);
    check({tag, "/cpu_hold"}, 32'(cpu_hold), 0);
    check({tag, "/cpu_rst_pulse"}, 32'(cpu_rst_pulse), 0);
    check({tag, "/done"}, 32'(done), 0);
    check({tag, "/byte_count"}, 32'(byte_count), 0);
    check({tag, "/frame_err"}, 32'(frame_err), 0);
    check({tag, "/chk_err"}, 32'(chk_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [4];
    int n_pre;
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;

    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();
    tick(4);

    // Full load with the reference program
    start_load();
    check("load/cpu_hold", 32'(cpu_hold), 1);
    for (int i = 0; i < DEPTH; i++) send_byte((i < 4) ? prog[i] : 8'h00, 1'b1);
    if (CHECKSUM) send_byte(m_sum, 1'b1);
    compare_state("full");
    stop_load();
    compare_state("full_off");

    // Framing error mid-load, then a randomized remainder
    start_load();
    n_pre = $urandom_range(1, 8);
    send_random(n_pre);
    send_byte(8'h55, 1'b0);
    compare_state("frame");
    send_byte(8'hAA, 1'b1);
    compare_state("frame_next");
    send_random(DEPTH - n_pre - 1);
    if (CHECKSUM) send_byte(m_sum, 1'b1);
    compare_state("random_full");
    stop_load();

    // Start-bit glitch, then abort after five bytes and restart
    start_load();
    send_random(2);
    uart_rx = 1'b0; tick(6);
    uart_rx = 1'b1; tick(40);
    compare_state("glitch");
    send_random(3);
    stop_load();
    compare_state("abort");
    start_load();
    compare_state("restart");
    send_random(1);
    compare_state("restart_byte");

    // Asynchronous reset during data bit 4
    send_random(2);
    compare_state("pre_rst");
    uart_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) begin uart_rx = 1'($urandom_range(0, 1)); tick(CPB); end
    uart_rx = 1'b1; tick(8);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    tick(3);
    rst = 1'b0;
    model_reset();
    start_load();
    compare_state("post_rst");
    send_random(DEPTH);
    if (CHECKSUM) send_byte(m_sum, 1'b1);
    compare_state("post_rst_full");
    stop_load();

`ifdef LOADER_CHECKSUM_EN
    start_load();
    for (int i = 0; i < DEPTH; i++) send_byte(8'h11, 1'b1);
    send_byte(8'h10, 1'b1);
    compare_state("chk_good");
    stop_load();
    start_load();
    for (int i = 0; i < DEPTH; i++) send_byte(8'h11, 1'b1);
    send_byte(8'h11, 1'b1);
    compare_state("chk_bad");
    stop_load();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
